sram_port_arbiter: RTL and testbench

//  Shares the single-port, 1-cycle-latency data SRAM between two requesters:
//  M0 = RV32E core data port (priority), M1 = secondary master (DMA/loader/debug).

---
 rtl/sram_port_arbiter.sv | 73 +++++++
 tb/tb_sram_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port, 1-cycle-latency SRAM between two masters.
//   clk, rst_n      : clock and asynchronous active-low reset
//   m0_* (priority) : req/we/be/addr/wdata in; gnt/rvalid/rdata out
//   m1_*            : same set as m0_*; protected from starvation by the M0 burst cap
//   sram_*          : active-low cen/wen/ben, addr and din out; dout in
module sram_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        sram_cen,
  output logic        sram_wen,
  output logic [3:0]  sram_ben,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt0;
  logic          rd_pend;
  logic          rd_own;
  logic          cap;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  // M0 has used its burst allowance while M1 waits: M1 takes this slot
  assign cap    = m1_req && (cnt0 == CW'(MAX_BURST));
  assign m0_gnt = rst_n && m0_req && !cap;
  assign m1_gnt = rst_n && m1_req && !m0_gnt;
  assign we     = m1_gnt ? m1_we : m0_we;
  assign be     = m1_gnt ? m1_be : m0_be;
  assign addr   = m1_gnt ? m1_addr : m0_addr;
  assign wdata  = m1_gnt ? m1_wdata : m0_wdata;
  assign sram_cen  = !(m0_gnt || m1_gnt);
  assign sram_wen  = sram_cen || !we;
  assign sram_ben  = sram_cen ? 4'hF : (we ? ~be : 4'h0);
  assign sram_addr = sram_cen ? '0 : addr;
  assign sram_din  = (!sram_cen && we) ? wdata : '0;
  // cnt0 cannot pass MAX_BURST: at the cap M0 loses the slot and the count clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0    <= '0;
      rd_pend <= 1'b0;
      rd_own  <= 1'b0;
    end else begin
      cnt0    <= (m0_gnt && m1_req) ? cnt0 + CW'(1) : '0;
      rd_pend <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
      rd_own  <= m1_gnt;
    end
  end
  // read data is steered to whichever port issued the read in the previous cycle
  assign m0_rvalid = rst_n && rd_pend && !rd_own;
  assign m1_rvalid = rst_n && rd_pend && rd_own;
  assign m0_rdata  = m0_rvalid ? sram_dout : '0;
  assign m1_rdata  = m1_rvalid ? sram_dout : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench with an SRAM model and a reference memory.
module tb_sram_port_arbiter;
  localparam int MB = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_be = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_be = '0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_ben;
  logic [31:0] sram_addr, sram_din, sram_dout;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  typedef struct {int due; logic [31:0] d;} exp_t;
  exp_t q [2][$];
  int cyc = 0;
  int streak = 0;
  int errors = 0;
  int checks = 0;

  sram_port_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_ben(sram_ben),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_ben[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr[5:2]];
      end
    end
  end

  task automatic chk(input string n, input logic [69:0] a, input logic [69:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Reference: grant per the priority/cap rule, SRAM strobes per selected request,
  // byte-masked write into ref_mem, and read expectations queued for the next cycle.
  always @(negedge clk) begin
    logic e0, e1, w;
    logic [3:0] be;
    logic [31:0] a, wd;
    logic [69:0] es;
    e0 = rst_n && m0_req && !(m1_req && streak == MB);
    e1 = rst_n && m1_req && !e0;
    chk("m0_gnt", 70'(m0_gnt), 70'(e0));
    chk("m1_gnt", 70'(m1_gnt), 70'(e1));
    w  = e1 ? m1_we : m0_we;
    be = e1 ? m1_be : m0_be;
    a  = e1 ? m1_addr : m0_addr;
    wd = e1 ? m1_wdata : m0_wdata;
    es = (e0 || e1) ? {1'b0, !w, (w ? ~be : 4'h0), a, (w ? wd : 32'h0)} : {2'b11, 4'hF, 64'h0};
    chk("sram_bus", {sram_cen, sram_wen, sram_ben, sram_addr, sram_din}, es);
    if ((e0 || e1) && w)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
    if ((e0 || e1) && !w) q[e1].push_back('{cyc + 1, ref_mem[a[5:2]]});
    streak = (e0 && m1_req) ? streak + 1 : 0;
  end

  always @(negedge clk) begin
    logic ev, v;
    logic [31:0] d;
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
    end
    for (int p = 0; p < 2; p++) begin
      v = p ? m1_rvalid : m0_rvalid;
      d = p ? m1_rdata : m0_rdata;
      ev = q[p].size() > 0 && q[p][0].due == cyc;
      chk(p ? "m1_rvalid" : "m0_rvalid", 70'(v), 70'(ev));
      chk(p ? "m1_rdata" : "m0_rdata", 70'(d), ev ? 70'(q[p][0].d) : 70'(0));
      if (q[p].size() > 0 && q[p][0].due <= cyc) void'(q[p].pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input logic r, input logic w, input logic [3:0] be,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      m1_req = r; m1_we = w; m1_be = be; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = r; m0_we = w; m0_be = be; m0_addr = a; m0_wdata = wd;
    end
  endtask

  task automatic issue(input bit p, input logic w, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    set_port(p, 1'b1, w, be, a, wd);
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (p ? m1_gnt : m0_gnt) break;
      if (i == 20) begin
        checks++;
        errors++;
        $display("FAIL grant_timeout: port %0d no grant after %0d cycles", p, i);
        break;
      end
    end
    step();
    set_port(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] seq;
    bit g [2];
    int held [2];
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    m0_req = 1'b1;
    m1_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 70'({m0_gnt, m1_gnt}), 70'(0));
      chk("rst_strobes", 70'({sram_cen, sram_wen, sram_ben}), 70'(6'h3F));
      chk("rst_rvalid", 70'({m0_rvalid, m1_rvalid}), 70'(0));
    end
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    rst_n = 1'b1;
    step();
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rd_full", 70'({m0_rvalid, m1_rvalid, m0_rdata}), {36'h0, 2'b10, 32'hDEADBEEF});
    step();
    issue(0, 1'b1, 4'b0010, 32'h10, 32'h0000AB00);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rd_partial", 70'({m0_rvalid, m0_rdata}), {37'h0, 1'b1, 32'hDEADABEF});
    step();
    set_port(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seq[i] = m1_gnt;
      step();
    end
    set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("burst_seq", 70'(seq), 70'(12'b0010_0001_0000));
    step();
    issue(0, 1'b1, 4'hF, 32'h20, 32'd5);
    issue(1, 1'b1, 4'hF, 32'h24, 32'd7);
    set_port(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    @(negedge clk);
    step();
    set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(1, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    chk("pipe_n1", 70'({m0_rvalid, m1_rvalid, m1_gnt, m0_rdata}), {35'h0, 3'b101, 32'd5});
    step();
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("pipe_n2", 70'({m0_rvalid, m1_rvalid, m1_rdata}), {36'h0, 2'b01, 32'd7});
    step();
    set_port(1, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    chk("rst6_gnt", 70'(m1_gnt), 70'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst6_drop", 70'(m1_rvalid), 70'(0));
    step();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst6_after", 70'({m0_rvalid, m1_rvalid}), 70'(0));
    end
    held[0] = 0;
    held[1] = 0;
    g[0] = 1'b0;
    g[1] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (!(p ? m1_req : m0_req) || g[p]) begin
          held[p] = 0;
          set_port(p[0], $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom),
                   32'($urandom_range(0, 15)) << 2, $urandom);
        end else if (++held[p] > 2 * MB) begin
          checks++;
          errors++;
          $display("FAIL starve: port %0d waiting %0d cycles", p, held[p]);
          held[p] = 0;
        end
      end
      @(negedge clk);
      g[0] = m0_gnt;
      g[1] = m1_gnt;
    end
    step();
    set_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) step();
    chk("drain", 70'(q[0].size() + q[1].size()), 70'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
